// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one stream sink between N sources.
// Optional forced release after MAX_BURST beats: define STREAM_RR_ARBITER_BURST_LIMIT_EN.
module stream_rr_arbiter #(
   parameter int DW        = 32,
   parameter int N         = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N*DW-1:0]                      s_data_i,
   input  logic [N-1:0]                         s_valid_i,
   input  logic [N-1:0]                         s_last_i,
   output logic [N-1:0]                         s_ready_o,
   output logic [DW-1:0]                        m_data_o,
   output logic                                 m_valid_o,
   output logic                                 m_last_o,
   input  logic                                 m_ready_i,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_id_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (N < 2 || N > 16) begin : g_bad_n
      $error("stream_rr_arbiter: N must be within 2..16");
   end
   if (MAX_BURST < 1 || MAX_BURST > 65535) begin : g_bad_burst
      $error("stream_rr_arbiter: MAX_BURST must be within 1..65535");
   end

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_grant_q, last_grant_d;
   logic            arb_found;
   logic [IW-1:0]   arb_pick;
   logic            out_xfer;
   logic            burst_release;

   // Rotating priority: the requester just after the previous winner is checked first.
   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      for (int i = 1; i <= N; i++) begin
         if (!arb_found && s_valid_i[(int'(last_grant_q) + i) % N]) begin
            arb_found = 1'b1;
            arb_pick  = IW'((int'(last_grant_q) + i) % N);
         end
      end
   end

   always_comb begin
      s_ready_o = '0;
      m_data_o  = '0;
      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      m_id_o    = grant_q;
      if (rst) begin
         m_id_o = '0;
      end else if (state_q == BUSY) begin
         m_data_o           = s_data_i[int'(grant_q)*DW +: DW];
         m_valid_o          = s_valid_i[grant_q];
         m_last_o           = s_last_i[grant_q];
         s_ready_o[grant_q] = m_ready_i;
      end
   end

   assign out_xfer = m_valid_o & m_ready_i;

`ifdef STREAM_RR_ARBITER_BURST_LIMIT_EN
   localparam int BW = $clog2(MAX_BURST + 1);

   logic [BW-1:0] burst_q, burst_d;

   // Counts beats of the current grant; m_last_o is left untouched on a forced release.
   always_comb begin
      burst_d       = burst_q;
      burst_release = 1'b0;
      if (state_q == IDLE) begin
         if (arb_found) begin
            burst_d = '0;
         end
      end else if (out_xfer) begin
         burst_d       = burst_q + BW'(1);
         burst_release = (burst_d == BW'(MAX_BURST));
      end
   end
`else
   assign burst_release = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d = BUSY;
               grant_d = arb_pick;
            end
         end
         BUSY: begin
            if (out_xfer && (m_last_o || burst_release)) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset parks last_grant at N-1 so the first arbitration favours requester 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IW'(N - 1);
`ifdef STREAM_RR_ARBITER_BURST_LIMIT_EN
         burst_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
`ifdef STREAM_RR_ARBITER_BURST_LIMIT_EN
         burst_q      <= burst_d;
`endif
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (N=4, DW=32).
module tb_stream_rr_arbiter;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int IW = 2;
`ifdef STREAM_RR_ARBITER_BURST_LIMIT_EN
   localparam int MB = 2;
`else
   localparam int MB = 16;
`endif

   logic            clk;
   logic            rst;
   logic [N*DW-1:0] s_data_i;
   logic [N-1:0]    s_valid_i;
   logic [N-1:0]    s_last_i;
   logic [N-1:0]    s_ready_o;
   logic [DW-1:0]   m_data_o;
   logic            m_valid_o;
   logic            m_last_o;
   logic            m_ready_i;
   logic [IW-1:0]   m_id_o;

   int checks   = 0;
   int failures = 0;

   stream_rr_arbiter #(
      .DW(DW),
      .N(N),
      .MAX_BURST(MB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_data_i(s_data_i),
      .s_valid_i(s_valid_i),
      .s_last_i(s_last_i),
      .s_ready_o(s_ready_o),
      .m_data_o(m_data_o),
      .m_valid_o(m_valid_o),
      .m_last_o(m_last_o),
      .m_ready_i(m_ready_i),
      .m_id_o(m_id_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input int k, input logic v, input logic [DW-1:0] d, input logic l);
      s_valid_i[k]         = v;
      s_data_i[k*DW +: DW] = d;
      s_last_i[k]          = l;
   endtask

   task automatic check_idle(input string tag);
      #1;
      check({tag, "_valid"}, 64'(m_valid_o), 64'(0));
      check({tag, "_last"},  64'(m_last_o),  64'(0));
      check({tag, "_ready"}, 64'(s_ready_o), 64'(0));
   endtask

   task automatic check_beat(input string tag, input int id, input logic [DW-1:0] d,
                             input logic l, input logic [N-1:0] rdy);
      #1;
      check({tag, "_valid"}, 64'(m_valid_o), 64'(1));
      check({tag, "_id"},    64'(m_id_o),    64'(id));
      check({tag, "_data"},  64'(m_data_o),  64'(d));
      check({tag, "_last"},  64'(m_last_o),  64'(l));
      check({tag, "_ready"}, 64'(s_ready_o), 64'(rdy));
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int beat [2];
      int exp_ids [8];

      rst       = 1'b1;
      s_valid_i = '0;
      s_last_i  = '0;
      s_data_i  = '0;
      m_ready_i = 1'b1;

      // Outputs held at zero while reset is high, even with all requests present
      tick();
      s_valid_i = '1;
      s_last_i  = '1;
      #1;
      check("rst_sready", 64'(s_ready_o), 64'(0));
      check("rst_valid",  64'(m_valid_o), 64'(0));
      check("rst_last",   64'(m_last_o),  64'(0));
      check("rst_id",     64'(m_id_o),    64'(0));
      tick();
      s_valid_i = '0;
      s_last_i  = '0;
      rst       = 1'b0;

      // Single requester: 3-beat packet from requester 2
      apply_stimulus(2, 1'b1, 32'hA0, 1'b0);
      check_idle("t1_arb");
      tick();
      check_beat("t1_b0", 2, 32'hA0, 1'b0, 4'b0100);
      tick();
      apply_stimulus(2, 1'b1, 32'hA1, 1'b0);
      check_beat("t1_b1", 2, 32'hA1, 1'b0, 4'b0100);
      tick();
      apply_stimulus(2, 1'b1, 32'hA2, 1'b1);
      check_beat("t1_b2", 2, 32'hA2, 1'b1, 4'b0100);
      tick();
      apply_stimulus(2, 1'b0, 32'h0, 1'b0);
      check_idle("t1_done");

      // Round robin: continuous single-beat packets on all requesters
      reset_pulse();
      for (int k = 0; k < N; k++) apply_stimulus(k, 1'b1, 32'h100 + k, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check_idle("t2_gap");
         tick();
         check_beat("t2_beat", i % N, 32'h100 + (i % N), 1'b1, N'(1) << (i % N));
         tick();
      end
      for (int k = 0; k < N; k++) apply_stimulus(k, 1'b0, 32'h0, 1'b0);
      check_idle("t2_done");

      // Backpressure: 4-beat packet from requester 1 with m_ready_i toggling
      tick();
      apply_stimulus(1, 1'b1, 32'hB0, 1'b0);
      check_idle("t3_arb");
      tick();
      for (int b = 0; b < 4; b++) begin
         if (b > 0) begin
            m_ready_i = 1'b0;
            check_beat("t3_hold", 1, 32'hB0 + b, b == 3, 4'b0000);
            tick();
         end
         m_ready_i = 1'b1;
         check_beat("t3_xfer", 1, 32'hB0 + b, b == 3, 4'b0010);
         tick();
         if (b < 3) apply_stimulus(1, 1'b1, 32'hB0 + b + 1, (b + 1) == 3);
         else       apply_stimulus(1, 1'b0, 32'h0, 1'b0);
      end
      check_idle("t3_done");

      // Grant lock: requester 0 stalls mid-packet while requester 3 waits
      tick();
      apply_stimulus(0, 1'b1, 32'hC0, 1'b0);
      check_idle("t4_arb");
      tick();
      apply_stimulus(3, 1'b1, 32'hD0, 1'b1);
      check_beat("t4_b0", 0, 32'hC0, 1'b0, 4'b0001);
      tick();
      apply_stimulus(0, 1'b1, 32'hC1, 1'b0);
      check_beat("t4_b1", 0, 32'hC1, 1'b0, 4'b0001);
      tick();
      apply_stimulus(0, 1'b0, 32'hC1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t4_stall_valid", 64'(m_valid_o), 64'(0));
         check("t4_stall_id",    64'(m_id_o),    64'(0));
         check("t4_stall_ready", 64'(s_ready_o), 64'(4'b0001));
         tick();
      end
      apply_stimulus(0, 1'b1, 32'hC2, 1'b1);
      check_beat("t4_b2", 0, 32'hC2, 1'b1, 4'b0001);
      tick();
      apply_stimulus(0, 1'b0, 32'h0, 1'b0);
      check_idle("t4_gap");
      tick();
      check_beat("t4_r3", 3, 32'hD0, 1'b1, 4'b1000);
      tick();
      apply_stimulus(3, 1'b0, 32'h0, 1'b0);
      check_idle("t4_done");

      // Reset during beat 2 of a requester-1 packet while requester 0 also waits
      tick();
      apply_stimulus(1, 1'b1, 32'hE0, 1'b0);
      check_idle("t5_arb");
      tick();
      apply_stimulus(0, 1'b1, 32'hF0, 1'b1);
      check_beat("t5_b0", 1, 32'hE0, 1'b0, 4'b0010);
      tick();
      apply_stimulus(1, 1'b1, 32'hE1, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_rst_ready", 64'(s_ready_o), 64'(0));
      check("t5_rst_valid", 64'(m_valid_o), 64'(0));
      check("t5_rst_last",  64'(m_last_o),  64'(0));
      check("t5_rst_id",    64'(m_id_o),    64'(0));
      check("t5_rst_data",  64'(m_data_o),  64'(0));
      tick();
      rst = 1'b0;
      check_idle("t5_post_rst");
      tick();
      check_beat("t5_first", 0, 32'hF0, 1'b1, 4'b0001);
      tick();
      apply_stimulus(0, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1, 1'b0, 32'h0, 1'b0);
      check_idle("t5_done");

`ifdef STREAM_RR_ARBITER_BURST_LIMIT_EN
      // Burst limit of 2 interleaves two 4-beat packets
      reset_pulse();
      beat[0] = 0;
      beat[1] = 0;
      exp_ids = '{0, 0, 1, 1, 0, 0, 1, 1};
      apply_stimulus(0, 1'b1, 32'h200, 1'b0);
      apply_stimulus(1, 1'b1, 32'h210, 1'b0);
      for (int j = 0; j < 8; j++) begin
         int k;
         k = exp_ids[j];
         if (j % 2 == 0) begin
            check_idle("t6_gap");
            tick();
         end
         check_beat("t6_beat", k, 32'h200 + 16 * k + beat[k], beat[k] == 3, N'(1) << k);
         tick();
         beat[k]++;
         if (beat[k] < 4) apply_stimulus(k, 1'b1, 32'h200 + 16 * k + beat[k], beat[k] == 3);
         else             apply_stimulus(k, 1'b0, 32'h0, 1'b0);
      end
      check_idle("t6_done");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one downstream stream sink between N requesting stream sources.
- Typical sink is a shared width converter (e.g. a downsizer) or an output port.
- The grant is locked for the whole packet, delimited by last, and released after the beat carrying last.
- Datapath is a registered-select mux: no data storage and no added data latency once a grant is held.

Parameters:
- DW, 32, data width of every input and of the output.
- N, 4, number of requesters; legal range 2..16.
- MAX_BURST, 16, beats per grant before forced release; used only with the optional feature; legal range 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_data_i  in  N*DW  requester data; requester k occupies bits [k*DW +: DW].
- s_valid_i  in  N  per-requester valid.
- s_last_i  in  N  per-requester end-of-packet flag.
- s_ready_o  out  N  per-requester ready.
- m_data_o  out  DW  granted data.
- m_valid_o  out  1  output valid.
- m_last_o  out  1  output last.
- m_ready_i  in  1  sink ready.
- m_id_o  out  max(1,$clog2(N))  index of the granted requester.

Behaviour:
- Transfers: a beat transfers on an input when s_valid_i[k] & s_ready_o[k], and on the output when m_valid_o & m_ready_i.
- State machine has two states, IDLE and BUSY. Registers: state, grant (index), last_grant (index).
- Reset: state=IDLE, grant=0, last_grant=N-1, burst count=0.
  - While rst is high: s_ready_o=0, m_valid_o=0, m_last_o=0, m_id_o=0.
- IDLE:
  - All s_ready_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=grant.
  - If any s_valid_i bit is set: grant <= first k with s_valid_i[k]=1, searching from last_grant+1 upward modulo N. State <= BUSY.
  - If no bit is set, remain in IDLE.
- BUSY:
  - m_data_o = s_data_i[grant]; m_valid_o = s_valid_i[grant]; m_last_o = s_last_i[grant]; m_id_o = grant.
  - s_ready_o[grant] = m_ready_i; all other s_ready_o bits = 0.
  - On an output transfer with m_last_o=1: state <= IDLE, last_grant <= grant.
  - Otherwise remain in BUSY with the grant locked, including while s_valid_i[grant] is low.
- Arbitration latency: exactly 1 idle cycle between packets. Arbitration takes a cycle, and the first beat can transfer in the cycle after arbitration.
- Fairness: a requester that holds valid waits for at most N-1 other packets.
- Requester valid changes: valid rising on a non-granted requester never preempts the current grant. A requester that drops valid while not granted is simply skipped.
- Single-beat packet (last on first beat): legal; returns to IDLE after the one transfer.
- Reset mid-packet: the grant is abandoned immediately. The arbiter emits no further beats from that packet, and the next packet arbitrates from requester 0.
- Purely combinational paths: m_ready_i -> s_ready_o and s_* -> m_* in BUSY. No combinational path from m_ready_i to m_valid_o.

Optional Feature:
- Macro: STREAM_RR_ARBITER_BURST_LIMIT_EN.
- When defined:
  - A burst counter, width $clog2(MAX_BURST+1), resets to 0 on each grant and increments on each output transfer.
  - When a transfer makes the count equal to MAX_BURST, release as if last: state <= IDLE, last_grant <= grant. m_last_o still shows the source last unmodified.
  - The remainder of that packet re-arbitrates normally later, giving bounded-latency interleaving. The sink must tolerate split packets.
- When undefined: no counter is present, and the grant is released only on last.

Test Plan:
- Single requester: N=4; requester 2 sends a 3-beat packet, last on beat 3, m_ready_i=1 -> m_id_o=2; beats appear on cycles 2,3,4 after valid rises; IDLE on cycle 5.
- Round robin:
  - Setup: all 4 requesters hold 1-beat packets continuously.
  - Required grant order: 0,1,2,3,0.
  - Required timing: one idle cycle between each beat, so each output beat occupies 2 cycles.
- Backpressure: m_ready_i toggles 1,0,1,0 during a 4-beat packet from requester 1 -> data is held stable while m_ready_i=0; s_ready_o[1] mirrors m_ready_i; s_ready_o of the other requesters stays 0; 4 beats arrive in order.
- Grant lock: requester 0 drops valid mid-packet for 3 cycles while requester 3 is valid -> requester 3 is not granted until requester 0 delivers its last beat.
- Reset mid-packet: assert rst during beat 2 of a 5-beat packet from requester 1 while requesters 0 and 1 are valid -> outputs 0 during rst; the first grant after reset is requester 0.
- Burst limit, with STREAM_RR_ARBITER_BURST_LIMIT_EN and MAX_BURST=2: requesters 0 and 1 each send 4-beat packets -> output beat sequence 0,0,1,1,0,0,1,1; m_last_o is asserted only on the 4th beat of each source.
